ifid_elastic_stage: RTL and testbench
=====================================

# ifid_elastic_stage

Parametrised, elastic successor to the fixed IF/ID latch. It sits between fetch and decode and holds up to two in-flight instruction/PC pairs, with a valid/ready handshake on both sides. It supports a synchronous flush for branch redirects. Decode fields (cond, type, Rn, Rd, Rm, shift, offset) are sliced from the head entry, so decode sees registered fields with no added latency.

## Interface
Parameters:
- AW, 32, PC width in bits.
- NOP_WORD, 32'h0000_0000, instruction word presented on INSTR_OUT when the stage is empty.

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- CLR_N  in  1  asynchronous, active-low reset.
- FLUSH  in  1  synchronous flush; empties the stage.
- IN_VALID  in  1  fetch presents an entry.
- IN_READY  out  1  stage can accept an entry this cycle.
- INSTR_IN  in  32  fetched instruction.
- PC_IN  in  AW  PC+4 of the fetched instruction.
- OUT_VALID  out  1  head entry is valid.
- OUT_READY  in  1  decode consumes the head this cycle.
- INSTR_OUT  out  32  head instruction, or NOP_WORD when empty.
- PC_OUT  out  AW  head PC, or 0 when empty.
- COND_OUT  out  4  INSTR_OUT[31:28].
- TYPE_OUT  out  3  INSTR_OUT[27:25].
- RN_OUT  out  4  INSTR_OUT[19:16].
- RD_OUT  out  4  INSTR_OUT[15:12].
- RM_OUT  out  4  INSTR_OUT[3:0].
- SHIFT_OUT  out  12  INSTR_OUT[11:0].
- OFFSET_OUT  out  24  INSTR_OUT[23:0].
- OCCUPANCY  out  2  number of valid entries, 0 to 2.

## Operation
- Storage consists of a head register (H) and a skid register (S), each holding {valid, instr, pc}. The stage is strictly in-order: S is never valid unless H is valid.
- Handshakes:
  - Accept occurs when IN_VALID && IN_READY.
  - Pop occurs when OUT_VALID && OUT_READY.
  - IN_READY = !S.valid. It is a registered function of state and never depends combinationally on OUT_READY.
  - OUT_VALID = H.valid.
- Next-state rules, applied on each edge:
  - Pop with S valid: S moves to H.
  - Pop with S empty: H becomes the accepted entry if there was an accept, otherwise H becomes empty.
  - No pop with H empty: H takes the accepted entry.
  - No pop with H full: S takes the accepted entry.
  - Accept and pop in the same cycle with only H full: H is replaced by the new entry and S stays empty. Occupancy stays 1.
- FLUSH has priority over every other rule. On the next edge, H and S both become invalid and any accept or pop in that cycle is discarded. IN_READY reads 1 in the cycle after a flush.
- When H is invalid, INSTR_OUT = NOP_WORD and PC_OUT = 0. The field outputs are slices of INSTR_OUT, so they reflect NOP_WORD.
- Register data is not required to be cleared when an entry is invalid. The outputs are muxed by valid.

## Timing
- Reset (CLR_N low, asynchronous) values: OUT_VALID=0, IN_READY=1, OCCUPANCY=0, INSTR_OUT=NOP_WORD, PC_OUT=0, and all field outputs are slices of NOP_WORD. Reset may assert mid-transfer; no entry survives it.
- Latency is one cycle from accept into an empty stage to OUT_VALID=1.
- Throughput is one entry per cycle when OUT_READY is held high.
- With a full stage and OUT_READY=1, IN_READY rises one cycle after the pop that empties S.
- OUT_VALID, INSTR_OUT and PC_OUT are stable while OUT_VALID=1 && OUT_READY=0. That hold is the stall behaviour.

## Configuration
- IFID_SKID_EN defined: 2-entry behaviour as described above.
- IFID_SKID_EN undefined:
  - S is removed, OCCUPANCY never exceeds 1, and IN_READY = !H.valid || OUT_READY. This is a combinational ready path.
  - All other behaviour, including reset values, flush and the NOP output, is unchanged.

## Test plan
- Reset then accept INSTR_IN=32'hE0812003, PC_IN=4 with OUT_READY=1 -> the next cycle shows OUT_VALID=1, COND_OUT=4'hE, RN_OUT=1, RD_OUT=2, RM_OUT=3, SHIFT_OUT=12'h003, PC_OUT=4.
- Hold OUT_READY=0 and offer three words A, B, C back-to-back -> A and B are accepted, IN_READY=0 while C is offered, OCCUPANCY=2, and INSTR_OUT holds A.
- From the full state, set OUT_READY=1 for 2 cycles -> the outputs show A then B, IN_READY returns to 1 the cycle after A pops, and C is accepted.
- Assert FLUSH together with an accept and a pop while OCCUPANCY=2 -> the next cycle shows OCCUPANCY=0, OUT_VALID=0, INSTR_OUT=NOP_WORD, and the offered word is lost.
- Pull CLR_N low asynchronously mid-stream between edges -> OUT_VALID drops to 0 immediately, IN_READY=1, and PC_OUT=0.
- Build without IFID_SKID_EN and stream with OUT_READY=1 continuously -> one entry per cycle, and OCCUPANCY never exceeds 1.

Source files
------------

// File: rtl/ifid_elastic_stage.sv
// ifid_elastic_stage: elastic IF/ID stage with head/skid registers, flush and sliced decode fields.
// Define IFID_SKID_EN for the 2-entry registered-ready variant; otherwise 1 entry with combinational ready.
module ifid_elastic_stage #(
  parameter int          AW       = 32,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic          CLK,
  input  logic          CLR_N,
  input  logic          FLUSH,
  input  logic          IN_VALID,
  output logic          IN_READY,
  input  logic [31:0]   INSTR_IN,
  input  logic [AW-1:0] PC_IN,
  output logic          OUT_VALID,
  input  logic          OUT_READY,
  output logic [31:0]   INSTR_OUT,
  output logic [AW-1:0] PC_OUT,
  output logic [3:0]    COND_OUT,
  output logic [2:0]    TYPE_OUT,
  output logic [3:0]    RN_OUT,
  output logic [3:0]    RD_OUT,
  output logic [3:0]    RM_OUT,
  output logic [11:0]   SHIFT_OUT,
  output logic [23:0]   OFFSET_OUT,
  output logic [1:0]    OCCUPANCY
);
  logic          h_valid;
  logic [31:0]   h_instr;
  logic [AW-1:0] h_pc;
  logic          accept, pop;
  assign accept = IN_VALID && IN_READY;
  assign pop    = h_valid && OUT_READY;
`ifdef IFID_SKID_EN
  logic          s_valid;
  logic [31:0]   s_instr;
  logic [AW-1:0] s_pc;
  assign IN_READY  = !s_valid;
  assign OCCUPANCY = {h_valid && s_valid, h_valid ^ s_valid};
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      h_valid <= 1'b0;
      h_instr <= '0;
      h_pc    <= '0;
      s_valid <= 1'b0;
      s_instr <= '0;
      s_pc    <= '0;
    end else if (FLUSH) begin
      h_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (pop && s_valid) begin
      h_valid <= 1'b1;
      h_instr <= s_instr;
      h_pc    <= s_pc;
      s_valid <= 1'b0;
    end else if (pop || !h_valid) begin
      // covers the accept-while-popping case: the new entry replaces H directly
      h_valid <= accept;
      if (accept) begin
        h_instr <= INSTR_IN;
        h_pc    <= PC_IN;
      end
    end else if (accept) begin
      s_valid <= 1'b1;
      s_instr <= INSTR_IN;
      s_pc    <= PC_IN;
    end
  end
`else
  assign IN_READY  = !h_valid || OUT_READY;
  assign OCCUPANCY = {1'b0, h_valid};
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      h_valid <= 1'b0;
      h_instr <= '0;
      h_pc    <= '0;
    end else if (FLUSH) begin
      h_valid <= 1'b0;
    end else if (pop || !h_valid) begin
      h_valid <= accept;
      if (accept) begin
        h_instr <= INSTR_IN;
        h_pc    <= PC_IN;
      end
    end
  end
`endif
  assign OUT_VALID  = h_valid;
  assign INSTR_OUT  = h_valid ? h_instr : NOP_WORD;
  assign PC_OUT     = h_valid ? h_pc : '0;
  assign COND_OUT   = INSTR_OUT[31:28];
  assign TYPE_OUT   = INSTR_OUT[27:25];
  assign RN_OUT     = INSTR_OUT[19:16];
  assign RD_OUT     = INSTR_OUT[15:12];
  assign RM_OUT     = INSTR_OUT[3:0];
  assign SHIFT_OUT  = INSTR_OUT[11:0];
  assign OFFSET_OUT = INSTR_OUT[23:0];
endmodule

// File: tb/tb_ifid_elastic_stage.sv
// tb_ifid_elastic_stage: scoreboard bench for ifid_elastic_stage; expectations follow IFID_SKID_EN if defined.
module tb_ifid_elastic_stage;
  localparam logic [31:0] NOP = 32'hE1A0_0000;
`ifdef IFID_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif
  logic        CLK = 0, CLR_N = 0, FLUSH = 0, IN_VALID = 0, OUT_READY = 0;
  logic [31:0] INSTR_IN = 0, PC_IN = 0;
  logic        IN_READY, OUT_VALID;
  logic [31:0] INSTR_OUT, PC_OUT;
  logic [3:0]  COND_OUT, RN_OUT, RD_OUT, RM_OUT;
  logic [2:0]  TYPE_OUT;
  logic [11:0] SHIFT_OUT;
  logic [23:0] OFFSET_OUT;
  logic [1:0]  OCCUPANCY;
  int errors = 0, checks = 0;
  logic [63:0] q[$];

  ifid_elastic_stage #(.AW(32), .NOP_WORD(NOP)) dut (
    .CLK(CLK), .CLR_N(CLR_N), .FLUSH(FLUSH), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .INSTR_IN(INSTR_IN), .PC_IN(PC_IN), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .INSTR_OUT(INSTR_OUT), .PC_OUT(PC_OUT), .COND_OUT(COND_OUT), .TYPE_OUT(TYPE_OUT),
    .RN_OUT(RN_OUT), .RD_OUT(RD_OUT), .RM_OUT(RM_OUT), .SHIFT_OUT(SHIFT_OUT),
    .OFFSET_OUT(OFFSET_OUT), .OCCUPANCY(OCCUPANCY)
  );

  always #5 CLK = ~CLK;

  // Drives one cycle (called at posedge+1), checks against the model mid-cycle, then advances the model.
  task automatic cycle(input logic v, input logic [31:0] w, input logic [31:0] p, input logic r, input logic f);
    logic [31:0] ei, ep;
    logic        er, acc, pp;
    IN_VALID = v; INSTR_IN = w; PC_IN = p; OUT_READY = r; FLUSH = f;
    #4;
    ei = q.size() ? q[0][63:32] : NOP;
    ep = q.size() ? q[0][31:0] : 32'h0;
    er = (DEPTH == 2) ? (q.size() < 2) : (q.size() == 0 || r);
    checks += 6;
    if (OUT_VALID !== (q.size() > 0)) begin errors++; $display("FAIL out_valid got=%b exp=%b", OUT_VALID, q.size() > 0); end
    if (IN_READY !== er) begin errors++; $display("FAIL in_ready got=%b exp=%b", IN_READY, er); end
    if (OCCUPANCY !== 2'(q.size())) begin errors++; $display("FAIL occupancy got=%0d exp=%0d", OCCUPANCY, q.size()); end
    if (INSTR_OUT !== ei) begin errors++; $display("FAIL instr_out got=%h exp=%h", INSTR_OUT, ei); end
    if (PC_OUT !== ep) begin errors++; $display("FAIL pc_out got=%h exp=%h", PC_OUT, ep); end
    if ({COND_OUT, TYPE_OUT, RN_OUT, RD_OUT, RM_OUT, SHIFT_OUT, OFFSET_OUT} !==
        {ei[31:28], ei[27:25], ei[19:16], ei[15:12], ei[3:0], ei[11:0], ei[23:0]}) begin
      errors++; $display("FAIL fields got=%h/%h exp=%h/%h", COND_OUT, OFFSET_OUT, ei[31:28], ei[23:0]);
    end
    acc = v && er;
    pp  = (q.size() > 0) && r;
    @(posedge CLK);
    if (f) q.delete();
    else begin
      if (pp) void'(q.pop_front());
      if (acc) q.push_back({w, p});
    end
    #1;
  endtask

  task automatic test_reset();
    CLR_N = 0;
    #3;
    checks += 6;
    if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", OUT_VALID); end
    if (IN_READY !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", IN_READY); end
    if (OCCUPANCY !== 2'd0) begin errors++; $display("FAIL reset_occ got=%0d exp=0", OCCUPANCY); end
    if (INSTR_OUT !== NOP) begin errors++; $display("FAIL reset_instr got=%h exp=%h", INSTR_OUT, NOP); end
    if (PC_OUT !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=0", PC_OUT); end
    if (COND_OUT !== 4'hE || SHIFT_OUT !== 12'h000) begin errors++; $display("FAIL reset_fields got=%h/%h exp=e/000", COND_OUT, SHIFT_OUT); end
    @(posedge CLK); #2; CLR_N = 1;
    @(posedge CLK); #1;
  endtask

  task automatic test_decode();
    cycle(1, 32'hE081_2003, 32'd4, 1, 0);
    checks++;
    if ({OUT_VALID, COND_OUT, RN_OUT, RD_OUT, RM_OUT, SHIFT_OUT, PC_OUT} !== {1'b1, 4'hE, 4'd1, 4'd2, 4'd3, 12'h003, 32'd4})
      begin errors++; $display("FAIL decode got=%b %h %h %h %h %h %h exp=1 e 1 2 3 003 4",
        OUT_VALID, COND_OUT, RN_OUT, RD_OUT, RM_OUT, SHIFT_OUT, PC_OUT); end
    cycle(0, 0, 0, 1, 0);
  endtask

  task automatic test_stall_fill();
    cycle(1, 32'hAAAA_0001, 32'h100, 0, 0);
    cycle(1, 32'hBBBB_0002, 32'h104, 0, 0);
    cycle(1, 32'hCCCC_0003, 32'h108, 0, 0);
    #4;
    checks += 2;
    if (OCCUPANCY !== 2'(DEPTH)) begin errors++; $display("FAIL stall_occ got=%0d exp=%0d", OCCUPANCY, DEPTH); end
    if (INSTR_OUT !== 32'hAAAA_0001) begin errors++; $display("FAIL stall_hold got=%h exp=aaaa0001", INSTR_OUT); end
    @(posedge CLK); #1;
    // drain while re-offering C until the model has taken it
    for (int i = 0; i < 4; i++) cycle(1, 32'hCCCC_0003, 32'h108, 1, 0);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 0);
    checks++;
    if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL drain_empty got=%b exp=0", OUT_VALID); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) cycle(1, 32'h1000_0000 + i, 32'h200 + 4 * i, 0, 0);
    cycle(1, 32'hDEAD_BEEF, 32'h300, 1, 1);
    checks += 3;
    if (OCCUPANCY !== 2'd0) begin errors++; $display("FAIL flush_occ got=%0d exp=0", OCCUPANCY); end
    if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL flush_valid got=%b exp=0", OUT_VALID); end
    if (INSTR_OUT !== NOP) begin errors++; $display("FAIL flush_nop got=%h exp=%h", INSTR_OUT, NOP); end
    cycle(0, 0, 0, 1, 0);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) cycle(1, 32'h2000_0000 + i, 32'h400 + 4 * i, 0, 0);
    #2; CLR_N = 0; #1;
    checks += 3;
    if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL arst_valid got=%b exp=0", OUT_VALID); end
    if (IN_READY !== 1'b1) begin errors++; $display("FAIL arst_ready got=%b exp=1", IN_READY); end
    if (PC_OUT !== 32'h0) begin errors++; $display("FAIL arst_pc got=%h exp=0", PC_OUT); end
    q.delete();
    IN_VALID = 0;
    @(posedge CLK); #2; CLR_N = 1;
    @(posedge CLK); #1;
    cycle(0, 0, 0, 1, 0);
  endtask

  task automatic test_back_to_back();
    int n0;
    n0 = checks;
    for (int i = 0; i < 20; i++) begin
      cycle(1, 32'h3000_0000 + i, 32'h500 + 4 * i, 1, 0);
      checks++;
      if (OCCUPANCY !== 2'd1) begin errors++; $display("FAIL stream_occ i=%0d got=%0d exp=1", i, OCCUPANCY); end
      checks++;
      if (INSTR_OUT !== 32'h3000_0000 + i) begin errors++; $display("FAIL stream_rate i=%0d got=%h exp=%h", i, INSTR_OUT, 32'h3000_0000 + i); end
    end
    cycle(0, 0, 0, 1, 0);
    if (checks == n0) errors++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++)
      cycle(1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 0);
  endtask

  initial begin
    test_reset();
    test_decode();
    test_stall_fill();
    test_flush();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
